inst_mem_loader: RTL

//   Writer side of the instruction memory: receives a program as a valid/ready byte stream,

---
 rtl/loader_pkg.sv | 22 ++
 rtl/inst_mem_loader_if.sv | 15 +
 rtl/loader_byte_packer.sv | 40 ++++
 rtl/inst_mem_loader.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
// Holds the FSM state enum, byte/word geometry and memory sizing defaults.
// Optional feature macro: LOADER_CHECKSUM_EN adds the CHECK state.
package loader_pkg;

  localparam int BYTE_W         = 8;
  localparam int BYTES_PER_WORD = 4;
  localparam int DEPTH_DEF      = 32;
  localparam int ADDR_W_DEF     = 5;
  localparam int WORD_W_DEF     = BYTE_W * BYTES_PER_WORD;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_COLLECT = 3'd1,
    S_WRITE   = 3'd2,
`ifdef LOADER_CHECKSUM_EN
    S_CHECK   = 3'd4,
`endif
    S_DONE    = 3'd3
  } loader_state_t;

endpackage

// File: rtl/inst_mem_loader_if.sv
// Valid/ready byte-stream bundle feeding the instruction-memory loader.
// Signals: in_valid, in_data (one byte), in_last (final program byte), in_ready.
// master = stream source, slave = loader.
interface inst_mem_loader_if;
  import loader_pkg::*;

  logic              in_valid;
  logic [BYTE_W-1:0] in_data;
  logic              in_last;
  logic              in_ready;

  modport master (output in_valid, output in_data, output in_last, input in_ready);
  modport slave  (input in_valid, input in_data, input in_last, output in_ready);

endinterface

// File: rtl/loader_byte_packer.sv
// Assembly register for one instruction word: steers each accepted byte into
// lane idx_i (lane 0 = bits [7:0]); clr_i zeroes the whole word, so lanes not
// written before a short final word stay 0.
// Ports: clk, rst, byte_i, valid_i, idx_i, clr_i -> word_o.
module loader_byte_packer
  import loader_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic [BYTE_W-1:0]         byte_i,
  input  logic                      valid_i,
  input  logic [1:0]                idx_i,
  input  logic                      clr_i,
  output logic [WORD_W_DEF-1:0]     word_o
);

  logic [WORD_W_DEF-1:0] word_q;

  // Word assembly register; clear wins over a byte write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_q <= 32'h0000_0000;
    end else if (clr_i) begin
      word_q <= 32'h0000_0000;
    end else if (valid_i) begin
      case (idx_i)
        2'd0:    word_q[7:0]   <= byte_i;
        2'd1:    word_q[15:8]  <= byte_i;
        2'd2:    word_q[23:16] <= byte_i;
        2'd3:    word_q[31:24] <= byte_i;
        default: word_q        <= word_q;
      endcase
    end else begin
      word_q <= word_q;
    end
  end

  assign word_o = word_q;

endmodule

// File: rtl/inst_mem_loader.sv
// Instruction-memory loader: packs a byte stream little-endian into 32-bit
// words and writes them to addresses 0,1,2,... while holding the CPU.
// Ports: clk, rst (async, active-high), start_i, in_if (byte stream, slave),
//   wr_en_o/wr_addr_o/wr_data_o (memory write), word_count_o, cpu_hold_o,
//   load_done_o, error_o (overflow or checksum failure).
// Optional macro LOADER_CHECKSUM_EN: after the last word, one extra byte is
//   accepted and compared against the XOR of all payload bytes.
module inst_mem_loader
  import loader_pkg::*;
#(
  parameter int DEPTH      = DEPTH_DEF,
  parameter int ADDR_WIDTH = ADDR_W_DEF,
  parameter int WORD_WIDTH = WORD_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  inst_mem_loader_if.slave      in_if,
  output logic                  wr_en_o,
  output logic [ADDR_WIDTH-1:0] wr_addr_o,
  output logic [WORD_WIDTH-1:0] wr_data_o,
  output logic [ADDR_WIDTH:0]   word_count_o,
  output logic                  cpu_hold_o,
  output logic                  load_done_o,
  output logic                  error_o
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  loader_state_t         state_q, state_d;
  logic [1:0]            byte_idx_q, byte_idx_d;
  logic [ADDR_WIDTH-1:0] word_ptr_q, word_ptr_d;
  logic [ADDR_WIDTH:0]   word_count_q, word_count_d;
  logic                  last_q, last_d;
  logic                  error_q, error_d;
  logic                  pack_clr_s;
  logic                  accept_s;
  logic [WORD_W_DEF-1:0] word_s;
`ifdef LOADER_CHECKSUM_EN
  logic [BYTE_W-1:0]     xor_q, xor_d;
`endif

  // Handshake and status are pure decodes of the state register.
  assign in_if.in_ready = (state_q == S_COLLECT)
`ifdef LOADER_CHECKSUM_EN
                          || (state_q == S_CHECK)
`endif
                          ;
  assign accept_s     = in_if.in_valid && in_if.in_ready;
  assign wr_en_o      = (state_q == S_WRITE);
  assign cpu_hold_o   = (state_q != S_IDLE) && (state_q != S_DONE);
  assign load_done_o  = (state_q == S_DONE);
  assign error_o      = error_q;
  assign wr_addr_o    = word_ptr_q;
  assign wr_data_o    = WORD_WIDTH'(word_s);
  assign word_count_o = word_count_q;

  loader_byte_packer u_packer (
    .clk     (clk),
    .rst     (rst),
    .byte_i  (in_if.in_data),
    .valid_i (accept_s && (state_q == S_COLLECT)),
    .idx_i   (byte_idx_q),
    .clr_i   (pack_clr_s),
    .word_o  (word_s)
  );

  // Loader state and counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      byte_idx_q   <= 2'd0;
      word_ptr_q   <= '0;
      word_count_q <= '0;
      last_q       <= 1'b0;
      error_q      <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      xor_q        <= 8'h00;
`endif
    end else begin
      state_q      <= state_d;
      byte_idx_q   <= byte_idx_d;
      word_ptr_q   <= word_ptr_d;
      word_count_q <= word_count_d;
      last_q       <= last_d;
      error_q      <= error_d;
`ifdef LOADER_CHECKSUM_EN
      xor_q        <= xor_d;
`endif
    end
  end

  // Next-state logic.
  always_comb begin
    state_d      = state_q;
    byte_idx_d   = byte_idx_q;
    word_ptr_d   = word_ptr_q;
    word_count_d = word_count_q;
    last_d       = last_q;
    error_d      = error_q;
    pack_clr_s   = 1'b0;
`ifdef LOADER_CHECKSUM_EN
    xor_d        = xor_q;
`endif
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_i) begin
          state_d      = S_COLLECT;
          byte_idx_d   = 2'd0;
          word_ptr_d   = '0;
          word_count_d = '0;
          last_d       = 1'b0;
          error_d      = 1'b0;
          pack_clr_s   = 1'b1;
`ifdef LOADER_CHECKSUM_EN
          xor_d        = 8'h00;
`endif
        end else begin
          state_d = state_q;
        end
      end
      S_COLLECT: begin
        if (accept_s) begin
          byte_idx_d = byte_idx_q + 2'd1;
          last_d     = in_if.in_last;
`ifdef LOADER_CHECKSUM_EN
          xor_d      = xor_q ^ in_if.in_data;
`endif
          // A word is complete on its 4th byte or on any byte flagged last.
          if (in_if.in_last || (byte_idx_q == 2'd3)) begin
            state_d = S_WRITE;
          end else begin
            state_d = S_COLLECT;
          end
        end else begin
          state_d = S_COLLECT;
        end
      end
      S_WRITE: begin
        word_ptr_d   = word_ptr_q + 1'b1;
        word_count_d = word_count_q + 1'b1;
        byte_idx_d   = 2'd0;
        pack_clr_s   = 1'b1;
        if (last_q) begin
`ifdef LOADER_CHECKSUM_EN
          state_d = S_CHECK;
`else
          state_d = S_DONE;
`endif
        end else if (word_ptr_q == LAST_ADDR) begin
          // Memory full with stream still running: stop, no wrap-around.
          state_d = S_DONE;
          error_d = 1'b1;
        end else begin
          state_d = S_COLLECT;
        end
      end
`ifdef LOADER_CHECKSUM_EN
      S_CHECK: begin
        // Single checksum byte; its in_last flag is irrelevant.
        if (accept_s) begin
          state_d = S_DONE;
          error_d = (in_if.in_data != xor_q);
        end else begin
          state_d = S_CHECK;
        end
      end
`endif
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule
